audio_clkgen: RTL and testbench

Parametrised audio clock generator. It derives the codec master clock (MCLK), bit clock (BCLK) and word-select clock (LRCLK) from the 50 MHz system clock. The MCLK divisor is programmable at run time and changes without glitches. BCLK and LRCLK are divided synchronously from MCLK, and the block emits single-cycle strobes in the system clock domain for the I2S serialiser. It replaces the fixed-ratio MCLK divider and feeds both the codec pins and the audio datapath.

---
 rtl/audio_clkgen.sv | 114 +++++++++++
 tb/tb_audio_clkgen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_clkgen.sv
// rtl/audio_clkgen.sv - audio MCLK/BCLK/LRCLK generator with glitch-free runtime MCLK divisor
module audio_clkgen #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_MDIV = 3,
  parameter int BDIV         = 2,
  parameter int LR_BITS      = 32
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             ien,
  input  logic             iload,
  input  logic [CNT_W-1:0] imdiv,
  output logic             omclk,
  output logic             obclk,
  output logic             olrclk,
  output logic             ostb_bfall,
  output logic             ostb_frame,
  output logic             obusy
);

  localparam int BW = (BDIV > 1) ? $clog2(BDIV) : 1;
  localparam int LW = (LR_BITS > 1) ? $clog2(LR_BITS) : 1;

  logic [CNT_W-1:0] mcnt;
  logic [CNT_W-1:0] mdiv;
  logic [CNT_W-1:0] pend;
  logic [BW-1:0]    bcnt;
  logic [LW-1:0]    lcnt;
  logic             mwrap;
  logic             mfall;
  logic             bwrap;
  logic             bfall;
  logic             lwrap;
  logic             lfall;
  logic             apply;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    mwrap    = (mcnt == mdiv - CNT_W'(1));
    mfall    = mwrap & omclk;
    bwrap    = (bcnt == BW'(BDIV - 1));
    bfall    = mfall & bwrap & obclk;
    lwrap    = (lcnt == LW'(LR_BITS - 1));
    lfall    = bfall & lwrap & olrclk;
    // Swapping the divisor only at an MCLK fall keeps every high phase intact.
    apply    = obusy & (~ien | mfall);
    load_val = (imdiv == '0) ? CNT_W'(1) : imdiv;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      mdiv  <= CNT_W'(DEFAULT_MDIV);
      pend  <= '0;
      obusy <= 1'b0;
    end else begin
      if (apply) mdiv <= pend;
      if (iload) begin
        pend  <= load_val;
        obusy <= 1'b1;
      end else if (apply) begin
        obusy <= 1'b0;
      end
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      mcnt       <= '0;
      bcnt       <= '0;
      lcnt       <= '0;
      omclk      <= 1'b0;
      obclk      <= 1'b0;
      olrclk     <= 1'b0;
      ostb_bfall <= 1'b0;
      ostb_frame <= 1'b0;
    end else if (!ien) begin
      mcnt       <= '0;
      bcnt       <= '0;
      lcnt       <= '0;
      omclk      <= 1'b0;
      obclk      <= 1'b0;
      olrclk     <= 1'b0;
      ostb_bfall <= 1'b0;
      ostb_frame <= 1'b0;
    end else begin
      ostb_bfall <= bfall;
      ostb_frame <= lfall;
      if (mwrap) begin
        mcnt  <= '0;
        omclk <= ~omclk;
      end else begin
        mcnt <= mcnt + CNT_W'(1);
      end
      // BCLK and LRCLK only ever change on MCLK falling edges.
      if (mfall) begin
        if (bwrap) begin
          bcnt  <= '0;
          obclk <= ~obclk;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end
      if (bfall) begin
        if (lwrap) begin
          lcnt   <= '0;
          olrclk <= ~olrclk;
        end else begin
          lcnt <= lcnt + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_clkgen.sv
// tb/tb_audio_clkgen.sv - directed table-driven bench for audio_clkgen
module tb_audio_clkgen;

  logic        iclk;
  logic        irst_n;
  logic        ien;
  logic        iload;
  logic [15:0] imdiv;
  logic        omclk;
  logic        obclk;
  logic        olrclk;
  logic        ostb_bfall;
  logic        ostb_frame;
  logic        obusy;

  int errors;
  int checks;
  int n;
  int bf_cnt;
  int fr_cnt;

  typedef struct {
    int         cyc;
    logic [5:0] exp;  // {mclk, bclk, lrclk, bfall, frame, busy}
  } vec_t;

  vec_t tbl[16];

  audio_clkgen #(
    .CNT_W(16),
    .DEFAULT_MDIV(3),
    .BDIV(2),
    .LR_BITS(32)
  ) dut (
    .iclk(iclk),
    .irst_n(irst_n),
    .ien(ien),
    .iload(iload),
    .imdiv(imdiv),
    .omclk(omclk),
    .obclk(obclk),
    .olrclk(olrclk),
    .ostb_bfall(ostb_bfall),
    .ostb_frame(ostb_frame),
    .obusy(obusy)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk);
    #1;
    n++;
  endtask

  task automatic chk(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {omclk, obclk, olrclk, ostb_bfall, ostb_frame, obusy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, n, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    irst_n = 1'b0;
    ien    = 1'b0;
    iload  = 1'b0;
    imdiv  = '0;
    #1;
    chk("reset_state", 6'b000000);
    step();
    step();
    irst_n = 1'b1;
    ien    = 1'b1;
    n      = 0;
  endtask

  task automatic run_table(input string name);
    bf_cnt = 0;
    fr_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      while (n < tbl[i].cyc) begin
        step();
        bf_cnt += int'(ostb_bfall);
        fr_cnt += int'(ostb_frame);
      end
      chk(name, tbl[i].exp);
    end
    chk_int({name, "_bfall_count"}, bf_cnt, 64);
    chk_int({name, "_frame_count"}, fr_cnt, 1);
  endtask

  initial begin
    int min_high;
    int run;
    int drops;
    logic prev_busy;
    int waited;

    errors = 0;
    checks = 0;
    n      = 0;
    irst_n = 1'b0;
    ien    = 1'b0;
    iload  = 1'b0;
    imdiv  = '0;

    tbl[0]  = '{2,    6'b000000};
    tbl[1]  = '{3,    6'b100000};
    tbl[2]  = '{5,    6'b100000};
    tbl[3]  = '{6,    6'b000000};
    tbl[4]  = '{9,    6'b100000};
    tbl[5]  = '{11,   6'b100000};
    tbl[6]  = '{12,   6'b010000};
    tbl[7]  = '{23,   6'b110000};
    tbl[8]  = '{24,   6'b000100};
    tbl[9]  = '{25,   6'b000000};
    tbl[10] = '{767,  6'b110000};
    tbl[11] = '{768,  6'b001100};
    tbl[12] = '{769,  6'b001000};
    tbl[13] = '{1535, 6'b111000};
    tbl[14] = '{1536, 6'b000110};
    tbl[15] = '{1537, 6'b000000};

    // Default divisor timing
    do_reset();
    run_table("defaults");

    // Load 5 while MCLK is high
    do_reset();
    step(); step(); step();
    iload = 1'b1; imdiv = 16'd5;
    step(); iload = 1'b0;
    chk("load5_pending", 6'b100001);
    step(); step();
    chk("load5_applied", 6'b000000);
    while (n < 10) step();
    chk("load5_low", 6'b000000);
    step();
    chk("load5_rise", 6'b100000);
    while (n < 15) step();
    chk("load5_high", 6'b100000);
    step();
    chk("load5_fall", 6'b010000);
    while (n < 21) step();
    chk("load5_rise2", 6'b110000);

    // Load 0 clamps to 1
    do_reset();
    iload = 1'b1; imdiv = 16'd0;
    step(); iload = 1'b0;
    chk("load0_pending", 6'b000001);
    while (n < 6) step();
    chk("load0_applied", 6'b000000);
    step();
    chk("load0_c7", 6'b100000);
    step();
    chk("load0_c8", 6'b010000);
    step();
    chk("load0_c9", 6'b110000);
    while (n < 12) step();
    chk("load0_c12", 6'b000100);
    while (n < 16) step();
    chk("load0_c16", 6'b010000);
    while (n < 20) step();
    chk("load0_c20", 6'b000100);

    // Load 7 overwritten by 4 before the fall
    do_reset();
    iload = 1'b1; imdiv = 16'd7;
    step(); iload = 1'b0;
    chk("ovr_first", 6'b000001);
    prev_busy = obusy;
    drops = 0;
    min_high = 1000;
    run = 0;
    while (n < 30) begin
      if (n == 3) begin
        iload = 1'b1; imdiv = 16'd4;
      end
      step();
      iload = 1'b0;
      if (prev_busy && !obusy) drops++;
      prev_busy = obusy;
      if (omclk) run++;
      else if (run > 0) begin
        if (run < min_high) min_high = run;
        run = 0;
      end
      if (n == 4)  chk("ovr_second", 6'b100001);
      if (n == 6)  chk("ovr_applied", 6'b000000);
      if (n == 9)  chk("ovr_c9", 6'b000000);
      if (n == 10) chk("ovr_c10", 6'b100000);
      if (n == 13) chk("ovr_c13", 6'b100000);
      if (n == 14) chk("ovr_c14", 6'b010000);
    end
    chk_int("ovr_busy_drops", drops, 1);
    chk_int("ovr_min_high_ge3", (min_high >= 3) ? 1 : 0, 1);

    // Disable, load while disabled, re-enable
    do_reset();
    while (n < 500) step();
    chk("dis_before", 6'b010000);
    ien = 1'b0;
    step();
    chk("dis_c501", 6'b000000);
    step();
    iload = 1'b1; imdiv = 16'd2;
    step(); iload = 1'b0;
    chk("dis_c503", 6'b000001);
    step();
    chk("dis_c504", 6'b000000);
    while (n < 510) step();
    ien = 1'b1;
    step();
    chk("ren_c511", 6'b000000);
    step();
    chk("ren_c512", 6'b100000);
    step();
    chk("ren_c513", 6'b100000);
    step();
    chk("ren_c514", 6'b000000);

    // Async reset mid-frame after a divisor change
    do_reset();
    while (n < 800) step();
    chk("mid_c800", 6'b001000);
    iload = 1'b1; imdiv = 16'd9;
    step(); iload = 1'b0;
    waited = 0;
    while (obusy && waited < 40) begin
      step();
      waited++;
    end
    chk_int("mid_load_applied", int'(obusy), 0);
    #2;
    irst_n = 1'b0;
    #1;
    chk("mid_async_reset", 6'b000000);
    do_reset();
    run_table("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
